control_multiciclo: RTL and testbench

- Multicycle control unit for the RV32I-subset datapath.
- Replaces the single-cycle opcode decoder with an FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memories, pulses PC/IR/register-file enables, and counts retired instructions.
- Supports the same instruction classes as the single-cycle decoder: I, R, S, Load, Branch, JAL. Load and JAL write back to the register file.

---
 rtl/control_multiciclo.sv | 164 ++++++++++++++++
 tb/tb_control_multiciclo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) for the RV32I-subset datapath.
// Define ILLEGAL_TRAP_EN to trap on unsupported opcodes; otherwise they retire as NOPs.
module control_multiciclo #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             pcwrite_o,
  output logic             irwrite_o,
  output logic             imem_req_o,
  output logic             regwrite_o,
  output logic             alusrc_o,
  output logic             memwrite_o,
  output logic             memread_o,
  output logic             memtoreg_o,
  output logic             branch_o,
  output logic             jalFlag_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             err_o
);
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;

  localparam int WC_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);

  logic [2:0]       state_q, state_d;
  logic [6:0]       op_q;
  logic [WC_W-1:0]  wait_q;
  logic [CNT_W-1:0] retired_q;
  logic             err_q;
  logic             is_i, is_r, is_s, is_l, is_b, is_j;
  logic             legal_in, waiting, ready_sel, timeout;

  assign is_i = (op_q == OP_I);
  assign is_r = (op_q == OP_R);
  assign is_s = (op_q == OP_S);
  assign is_l = (op_q == OP_L);
  assign is_b = (op_q == OP_B);
  assign is_j = (op_q == OP_J);

  assign legal_in = (opcode_i == OP_I) || (opcode_i == OP_R) || (opcode_i == OP_S) ||
                    (opcode_i == OP_L) || (opcode_i == OP_B) || (opcode_i == OP_J);

  // The wait counter saturates at WAIT_MAX; a ready in that same cycle still wins.
  assign waiting   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign ready_sel = (state_q == ST_FETCH) ? imem_ready_i : dmem_ready_i;
  assign timeout   = (WAIT_MAX > 0) && waiting && !ready_sel && (wait_q == WC_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (imem_ready_i) state_d = ST_DECODE;
                 else if (timeout) state_d = ST_TRAP;
      ST_DECODE: begin
        if (legal_in) state_d = ST_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        if (is_b)              state_d = ST_FETCH;
        else if (is_s || is_l) state_d = ST_MEM;
        else                   state_d = ST_WB;
      end
      ST_MEM:    if (dmem_ready_i) state_d = is_s ? ST_FETCH : ST_WB;
                 else if (timeout) state_d = ST_TRAP;
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pcwrite_o  = 1'b0;
    irwrite_o  = 1'b0;
    imem_req_o = 1'b0;
    regwrite_o = 1'b0;
    alusrc_o   = 1'b0;
    memwrite_o = 1'b0;
    memread_o  = 1'b0;
    memtoreg_o = 1'b0;
    branch_o   = 1'b0;
    jalFlag_o  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        irwrite_o  = imem_ready_i;
      end
      ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        pcwrite_o = 1'b0;
`else
        pcwrite_o = !legal_in;
`endif
      end
      ST_EXEC: begin
        alusrc_o  = is_i || is_s || is_l;
        branch_o  = is_b;
        pcwrite_o = is_b;
        jalFlag_o = is_j;
      end
      ST_MEM: begin
        alusrc_o   = 1'b1;
        memwrite_o = is_s;
        memread_o  = is_l;
        memtoreg_o = is_l;
        pcwrite_o  = is_s && dmem_ready_i;
      end
      ST_WB: begin
        regwrite_o = 1'b1;
        pcwrite_o  = 1'b1;
        memtoreg_o = is_l;
        jalFlag_o  = is_j;
      end
      default: ;
    endcase
  end

  // Every retire point is exactly the cycle that advances the PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_DECODE) op_q <= opcode_i;
      if (state_d != state_q) wait_q <= '0;
      else if (waiting && (wait_q != WC_MAX)) wait_q <= wait_q + 1'b1;
      if (pcwrite_o) retired_q <= retired_q + 1'b1;
      if (state_d == ST_TRAP) err_q <= 1'b1;
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: per-instruction cycle scripts built from the instruction
// class rules, played against the DUT with random memory wait states.
module tb_control_multiciclo;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;
  localparam int W        = 14;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, WBS = 3'd4, T = 3'd5;
  // enable bits: pc ir req rw as mw mr mt br jl
  localparam logic [9:0] E_PC  = 10'b1000000000;
  localparam logic [9:0] E_IR  = 10'b0100000000;
  localparam logic [9:0] E_REQ = 10'b0010000000;
  localparam logic [9:0] E_RW  = 10'b0001000000;
  localparam logic [9:0] E_AS  = 10'b0000100000;
  localparam logic [9:0] E_MW  = 10'b0000010000;
  localparam logic [9:0] E_MR  = 10'b0000001000;
  localparam logic [9:0] E_MT  = 10'b0000000100;
  localparam logic [9:0] E_BR  = 10'b0000000010;
  localparam logic [9:0] E_JL  = 10'b0000000001;

  localparam logic [6:0] OP_I = 7'b0010011, OP_R = 7'b0110011, OP_S = 7'b0100011;
  localparam logic [6:0] OP_L = 7'b0000011, OP_B = 7'b1100011, OP_J = 7'b1101111;

  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] opcode = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic pcwrite, irwrite, imem_req, regwrite, alusrc, memwrite, memread, memtoreg, branch, jal_flag;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;
  logic err;

  int checks = 0, errors = 0;
  int retired_m = 0;
  logic [W-1:0] exp_q[$];
  logic [8:0]   stim_q[$];

  control_multiciclo #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode),
    .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .pcwrite_o(pcwrite), .irwrite_o(irwrite), .imem_req_o(imem_req),
    .regwrite_o(regwrite), .alusrc_o(alusrc), .memwrite_o(memwrite),
    .memread_o(memread), .memtoreg_o(memtoreg), .branch_o(branch),
    .jalFlag_o(jal_flag), .state_o(state), .retired_o(retired), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] obs_vec();
    return {state, pcwrite, irwrite, imem_req, regwrite, alusrc, memwrite,
            memread, memtoreg, branch, jal_flag, err};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_I) || (op == OP_R) || (op == OP_S) || (op == OP_L) ||
           (op == OP_B) || (op == OP_J);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic push_cyc(input logic [2:0] st, input logic [9:0] en, input logic im,
                          input logic dm, input logic [6:0] op, input logic er);
    exp_q.push_back({st, en, er});
    stim_q.push_back({im, dm, op});
  endtask

  // Expand one instruction into its expected cycle-by-cycle outputs and inputs.
  task automatic build(input logic [6:0] op, input int di, input int dd, output bit trapped);
    bit s_i, s_s, s_l, s_b, s_j;
    logic [9:0] mem_en;
    s_i = (op == OP_I); s_s = (op == OP_S); s_l = (op == OP_L);
    s_b = (op == OP_B); s_j = (op == OP_J);
    trapped = 1'b0;
    for (int j = 0; j < di; j++) begin
      push_cyc(F, E_REQ, 1'b0, rnd_bit(), rnd_op(), 1'b0);
      if (j == WAIT_MAX) begin trapped = 1'b1; return; end
    end
    push_cyc(F, E_REQ | E_IR, 1'b1, rnd_bit(), rnd_op(), 1'b0);
    if (!is_legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
      push_cyc(D, 10'b0, rnd_bit(), rnd_bit(), op, 1'b0);
      trapped = 1'b1;
`else
      push_cyc(D, E_PC, rnd_bit(), rnd_bit(), op, 1'b0);
`endif
      return;
    end
    push_cyc(D, 10'b0, rnd_bit(), rnd_bit(), op, 1'b0);
    push_cyc(E, ((s_i || s_s || s_l) ? E_AS : 10'b0) | (s_b ? (E_BR | E_PC) : 10'b0) |
                (s_j ? E_JL : 10'b0), rnd_bit(), rnd_bit(), rnd_op(), 1'b0);
    if (s_b) return;
    if (s_s || s_l) begin
      mem_en = E_AS | (s_s ? E_MW : 10'b0) | (s_l ? (E_MR | E_MT) : 10'b0);
      for (int j = 0; j < dd; j++) begin
        push_cyc(M, mem_en, rnd_bit(), 1'b0, rnd_op(), 1'b0);
        if (j == WAIT_MAX) begin trapped = 1'b1; return; end
      end
      push_cyc(M, mem_en | (s_s ? E_PC : 10'b0), rnd_bit(), 1'b1, rnd_op(), 1'b0);
      if (s_s) return;
    end
    push_cyc(WBS, E_RW | E_PC | (s_l ? E_MT : 10'b0) | (s_j ? E_JL : 10'b0),
             rnd_bit(), rnd_bit(), rnd_op(), 1'b0);
  endtask

  // Play the scripted cycles; limit>0 stops early, dropping the rest of the script.
  task automatic run_queue(input int limit);
    logic [W-1:0] vec;
    logic [8:0] s;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      if (limit > 0 && n == limit) begin
        exp_q.delete();
        stim_q.delete();
        break;
      end
      vec = exp_q.pop_front();
      s = stim_q.pop_front();
      @(negedge clk);
      imem_ready = s[8];
      dmem_ready = s[7];
      opcode = s[6:0];
      #1;
      check("outputs", 32'(obs_vec()), 32'(vec));
      check("retired", 32'(retired), 32'(retired_m));
      if (vec[10]) retired_m = (retired_m + 1) % (1 << CNT_W);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode = rnd_op();
    @(posedge clk);
    #1;
    rst = 1'b0;
    retired_m = 0;
    check("reset_outputs", 32'(obs_vec()), 32'({F, E_REQ, 1'b0}));
    check("reset_retired", 32'(retired), 32'd0);
  endtask

  task automatic run_instr(input logic [6:0] op, input int di, input int dd, input int abort_at);
    bit trapped;
    build(op, di, dd, trapped);
    if (trapped) for (int k = 0; k < 3; k++) push_cyc(T, 10'b0, rnd_bit(), rnd_bit(), rnd_op(), 1'b1);
    run_queue(abort_at);
    if (trapped || abort_at > 0) do_reset();
  endtask

  function automatic int rnd_delay();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [6:0] op;
    logic [6:0] op_tab[6];
    op_tab[0] = OP_I; op_tab[1] = OP_R; op_tab[2] = OP_S;
    op_tab[3] = OP_L; op_tab[4] = OP_B; op_tab[5] = OP_J;

    do_reset();
    run_instr(OP_R, 0, 0, 0);
    run_instr(OP_L, 0, 3, 0);
    run_instr(OP_S, 0, 0, 0);
    run_instr(OP_B, 0, 0, 0);
    run_instr(OP_J, 2, 0, 0);
    run_instr(OP_I, WAIT_MAX, 0, 0);
    run_instr(OP_S, 1, WAIT_MAX, 0);
    run_instr(7'b1110011, 0, 0, 0);
    run_instr(OP_R, WAIT_MAX + 2, 0, 0);
    run_instr(OP_S, 0, WAIT_MAX + 3, 0);
    run_instr(OP_L, 0, 3, 5);

    do_reset();
    for (int k = 0; k < 17; k++) run_instr(OP_R, 0, 0, 0);
    @(posedge clk);
    #1;
    check("wrap_count", 32'(retired), 32'd1);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rnd_op(); while (is_legal(op));
      end else begin
        op = op_tab[$urandom_range(0, 5)];
      end
      run_instr(op, rnd_delay(), rnd_delay(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
